// File: rtl/spi_jedec_id_reader.sv
// ---------------------------------------------------------------------------
// spi_jedec_id_reader
//
// SPI master (mode 0) that sends the JEDEC Read-ID command to the serial
// flash and captures the three ID bytes that come back. The captured bytes
// stay on the outputs until the next transaction completes or reset asserts.
//
// Parameters
//   CLK_DIV : clk cycles per SCK half-period (1 or more)
//   CMD     : command byte shifted out MSB first before the read phase
//
// Ports
//   clk             : system clock, rising edge
//   reset           : synchronous active-high reset
//   start           : one-cycle request for an ID read, looked at only in IDLE
//   busy            : transaction in progress
//   done            : one-cycle pulse when the ID outputs are updated
//   id_valid        : at least one transaction completed since reset
//   manufacture_id  : first ID byte
//   memory_type     : second ID byte
//   memory_capacity : third ID byte
//   spi_sck         : SPI clock, idles low
//   spi_cs_n        : flash chip select, active low
//   spi_mosi        : master out
//   spi_miso        : master in
// ---------------------------------------------------------------------------
module spi_jedec_id_reader #(
  parameter int         CLK_DIV = 4,
  parameter logic [7:0] CMD     = 8'h9F
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       id_valid,
  output logic [7:0] manufacture_id,
  output logic [7:0] memory_type,
  output logic [7:0] memory_capacity,
  output logic       spi_sck,
  output logic       spi_cs_n,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int                DIV_W    = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SHIFT    = 3'd2,
    CS_HOLD  = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t           state_r;
  logic [DIV_W-1:0] div_cnt_r;
  logic [5:0]       bit_cnt_r;
  logic [23:0]      shift_r;
  logic             busy_r;
  logic             done_r;
  logic             id_valid_r;
  logic [7:0]       manufacture_id_r;
  logic [7:0]       memory_type_r;
  logic [7:0]       memory_capacity_r;
  logic             sck_r;
  logic             cs_n_r;
  logic             mosi_r;

  // MOSI value for a given bit slot: command byte in slots 0-7, zeros after.
  function automatic logic cmd_bit(input logic [5:0] idx);
    logic b;
    if (idx < 6'd8) begin
      b = CMD[3'd7 - idx[2:0]];
    end else begin
      b = 1'b0;
    end
    return b;
  endfunction

  // Transaction sequencer, SCK generator, shift register and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r           <= IDLE;
      div_cnt_r         <= '0;
      bit_cnt_r         <= 6'd0;
      shift_r           <= 24'h000000;
      busy_r            <= 1'b0;
      done_r            <= 1'b0;
      id_valid_r        <= 1'b0;
      manufacture_id_r  <= 8'h00;
      memory_type_r     <= 8'h00;
      memory_capacity_r <= 8'h00;
      sck_r             <= 1'b0;
      cs_n_r            <= 1'b1;
      mosi_r            <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r   <= CS_SETUP;
            cs_n_r    <= 1'b0;
            busy_r    <= 1'b1;
            mosi_r    <= CMD[7];
            div_cnt_r <= '0;
            bit_cnt_r <= 6'd0;
          end
        end

        CS_SETUP: begin
          if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= '0;
            state_r   <= SHIFT;
          end else begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
          end
        end

        SHIFT: begin
          if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= '0;
            if (!sck_r) begin
              // Rising edge: only the 24 samples after the command byte are kept.
              sck_r <= 1'b1;
              if (bit_cnt_r >= 6'd8) begin
                shift_r <= {shift_r[22:0], spi_miso};
              end
            end else begin
              // Falling edge: end of one bit period, present the next MOSI bit.
              sck_r <= 1'b0;
              if (bit_cnt_r == 6'd31) begin
                state_r <= CS_HOLD;
                mosi_r  <= 1'b0;
              end else begin
                bit_cnt_r <= bit_cnt_r + 6'd1;
                mosi_r    <= cmd_bit(bit_cnt_r + 6'd1);
              end
            end
          end else begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
          end
        end

        CS_HOLD: begin
          if (div_cnt_r == DIV_LAST) begin
            // All three bytes load together so consumers never see a mix.
            div_cnt_r         <= '0;
            state_r           <= DONE;
            cs_n_r            <= 1'b1;
            busy_r            <= 1'b0;
            done_r            <= 1'b1;
            id_valid_r        <= 1'b1;
            manufacture_id_r  <= shift_r[23:16];
            memory_type_r     <= shift_r[15:8];
            memory_capacity_r <= shift_r[7:0];
          end else begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
          end
        end

        DONE: begin
          // start is deliberately not looked at here, giving two cs_n-high cycles.
          state_r   <= IDLE;
          bit_cnt_r <= 6'd0;
        end

        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          sck_r   <= 1'b0;
          cs_n_r  <= 1'b1;
          mosi_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy            = busy_r;
  assign done            = done_r;
  assign id_valid        = id_valid_r;
  assign manufacture_id  = manufacture_id_r;
  assign memory_type     = memory_type_r;
  assign memory_capacity = memory_capacity_r;
  assign spi_sck         = sck_r;
  assign spi_cs_n        = cs_n_r;
  assign spi_mosi        = mosi_r;

endmodule

// File: tb/tb_spi_jedec_id_reader.sv
// ---------------------------------------------------------------------------
// Testbench for spi_jedec_id_reader: two instances (CLK_DIV=4 and CLK_DIV=1),
// each with a behavioural flash model. Stimulus pushes expected ID words into
// a scoreboard queue; a negedge monitor pops and compares on every done pulse
// and checks SPI framing (cs_n low time, SCK count, MOSI pattern, gaps).
// ---------------------------------------------------------------------------
module tb_spi_jedec_id_reader;

  localparam logic [7:0] CMD = 8'h9F;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]      start_v = 2'b00;
  logic [1:0]      busy_v, done_v, idv_v, sck_v, csn_v, mosi_v;
  logic [1:0]      miso_v = 2'b00;
  logic [1:0][7:0] mid_v, mt_v, mc_v;

  spi_jedec_id_reader #(.CLK_DIV(4), .CMD(CMD)) u_div4 (
    .clk(clk), .reset(reset), .start(start_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .id_valid(idv_v[0]), .manufacture_id(mid_v[0]),
    .memory_type(mt_v[0]), .memory_capacity(mc_v[0]), .spi_sck(sck_v[0]),
    .spi_cs_n(csn_v[0]), .spi_mosi(mosi_v[0]), .spi_miso(miso_v[0])
  );

  spi_jedec_id_reader #(.CLK_DIV(1), .CMD(CMD)) u_div1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .id_valid(idv_v[1]), .manufacture_id(mid_v[1]),
    .memory_type(mt_v[1]), .memory_capacity(mc_v[1]), .spi_sck(sck_v[1]),
    .spi_cs_n(csn_v[1]), .spi_mosi(mosi_v[1]), .spi_miso(miso_v[1])
  );

  // Scoreboard and flash contents
  logic [23:0] exp_q   [2][$];
  logic [23:0] flash_q [2][$];

  int vectors = 0;
  int miscompares = 0;

  // Monitor / flash model state
  logic [1:0]  prev_cs = 2'b11;
  logic [1:0]  prev_sck = 2'b00;
  logic [1:0]  prev_done = 2'b00;
  logic [1:0]  exp_idv = 2'b00;
  logic [1:0]  stuck = 2'b00;
  logic        rst_prev = 1'b0;
  logic        end_req = 1'b0;
  logic        end_done = 1'b0;
  int          low_cnt [2];
  int          high_cnt [2];
  int          rise_cnt [2];
  int          pidx [2];
  logic [31:0] mosi_bits [2];
  logic [23:0] cur_id [2];
  logic [23:0] last_id [2];

  function automatic int div_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  task automatic chk(input int i, input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL dut%0d %s: got %0h expected %0h at %0t", i, name, act, exp, $time);
    end
  endtask

  // Flash answer for bit period p: junk during the command byte, then the ID MSB first.
  function automatic logic flash_bit(input int i, input int p);
    logic b;
    if (stuck[i]) b = 1'b0;
    else if (p < 8) b = 1'($urandom_range(1, 0));
    else if (p > 31) b = 1'b0;
    else b = cur_id[i][31 - p];
    return b;
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      low_cnt[i] = 0; high_cnt[i] = 100; rise_cnt[i] = 0; pidx[i] = 0;
      mosi_bits[i] = 32'h0; cur_id[i] = 24'h0; last_id[i] = 24'h0;
    end
  end

  // Monitor + flash model: scoreboard compare on done, framing checks on cs_n edges.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_prev) begin
        chk(i, "reset state",
            64'({busy_v[i], done_v[i], idv_v[i], mid_v[i], mt_v[i], mc_v[i], sck_v[i], csn_v[i], mosi_v[i]}),
            64'({3'b000, 24'h000000, 3'b010}));
        exp_q[i].delete();
        exp_idv[i] = 1'b0;
        last_id[i] = 24'h0;
        high_cnt[i] = 100;
      end else begin
        if (done_v[i]) begin
          chk(i, "done pulse width", 64'(prev_done[i]), 64'(0));
          chk(i, "done with cs_n release", 64'({prev_cs[i], csn_v[i], busy_v[i]}), 64'(3'b010));
          chk(i, "transaction pending at done", 64'(exp_q[i].size() > 0), 64'(1));
          if (exp_q[i].size() > 0) begin
            last_id[i] = exp_q[i].pop_front();
            chk(i, "id bytes", 64'({mid_v[i], mt_v[i], mc_v[i]}), 64'(last_id[i]));
          end
          exp_idv[i] = 1'b1;
          chk(i, "id_valid at done", 64'(idv_v[i]), 64'(1));
        end

        if (prev_cs[i] && !csn_v[i]) begin
          cur_id[i] = (flash_q[i].size() > 0) ? flash_q[i].pop_front() : 24'($urandom);
          pidx[i] = 0;
          miso_v[i] = flash_bit(i, 0);
          low_cnt[i] = 1;
          rise_cnt[i] = 0;
          mosi_bits[i] = 32'h0;
          chk(i, "cs_n high gap >= 2", 64'(high_cnt[i] >= 2), 64'(1));
          chk(i, "busy at cs_n fall", 64'(busy_v[i]), 64'(1));
        end else if (!prev_cs[i] && !csn_v[i]) begin
          low_cnt[i]++;
          if (!prev_sck[i] && sck_v[i]) begin
            rise_cnt[i]++;
            mosi_bits[i] = {mosi_bits[i][30:0], mosi_v[i]};
            chk(i, "ids held during transfer",
                64'({idv_v[i], mid_v[i], mt_v[i], mc_v[i]}), 64'({exp_idv[i], last_id[i]}));
          end else if (prev_sck[i] && !sck_v[i]) begin
            pidx[i]++;
            miso_v[i] = flash_bit(i, pidx[i]);
          end
        end else if (!prev_cs[i] && csn_v[i]) begin
          chk(i, "cs_n low cycles", 64'(low_cnt[i]), 64'(66 * div_of(i)));
          chk(i, "sck rising edges", 64'(rise_cnt[i]), 64'(32));
          chk(i, "mosi pattern", 64'(mosi_bits[i]), 64'({CMD, 24'h000000}));
          high_cnt[i] = 1;
        end else begin
          high_cnt[i]++;
        end
      end
      prev_cs[i] = csn_v[i];
      prev_sck[i] = sck_v[i];
      prev_done[i] = done_v[i];
    end
    if (end_req && !end_done) begin
      for (int i = 0; i < 2; i++) chk(i, "scoreboard drained", 64'(exp_q[i].size()), 64'(0));
      end_done = 1'b1;
    end
    rst_prev = reset;
  end

  task automatic pulse(input int i);
    start_v[i] = 1'b1;
    @(posedge clk); #1;
    start_v[i] = 1'b0;
  endtask

  task automatic launch(input int i, input logic [23:0] id);
    flash_q[i].push_back(id);
    exp_q[i].push_back(stuck[i] ? 24'h000000 : id);
    pulse(i);
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n > 3000) begin
        $display("FAIL dut%0d wait for done: got timeout expected done pulse", i);
        $fatal(1, "timeout");
      end
    end while (exp_q[i].size() != 0);
  endtask

  task automatic wait_rise(input int i, input int k);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n > 3000) begin
        $display("FAIL dut%0d wait for sck edge %0d: got timeout expected edge", i, k);
        $fatal(1, "timeout");
      end
    end while (rise_cnt[i] < k);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Known ID, plus a stray start in SCK period 10 that must be ignored.
    launch(0, 24'hEF4018);
    wait_rise(0, 10);
    pulse(0);
    wait_idle(0);

    // Reset during the read phase, then a clean transaction.
    launch(0, 24'($urandom));
    wait_rise(0, 15);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    launch(0, 24'($urandom));
    wait_idle(0);

    // start held high: two back-to-back transactions.
    flash_q[0].push_back(24'hC22016); exp_q[0].push_back(24'hC22016);
    flash_q[0].push_back(24'h010203); exp_q[0].push_back(24'h010203);
    start_v[0] = 1'b1;
    wait_idle(0);
    start_v[0] = 1'b0;
    repeat (10) @(posedge clk); #1;

    // Fastest divider.
    launch(1, 24'hFF00AA);
    wait_idle(1);

    // miso stuck low.
    stuck[0] = 1'b1;
    launch(0, 24'h123456);
    wait_idle(0);
    stuck[0] = 1'b0;

    // Random IDs on both instances, some with an ignored mid-transfer start.
    for (int k = 0; k < 8; k++) begin
      int i;
      i = k % 2;
      launch(i, 24'($urandom));
      if ($urandom_range(1, 0) == 1) begin
        wait_rise(i, $urandom_range(31, 1));
        pulse(i);
      end
      wait_idle(i);
      repeat ($urandom_range(5, 0)) @(posedge clk);
      #1;
    end

    repeat (20) @(posedge clk);
    #1 end_req = 1'b1;
    repeat (3) @(posedge clk);
    if (!end_done) begin
      $display("FAIL final scoreboard check: got not run expected run");
      $fatal(1, "monitor stalled");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
